rv_issue_wb: RTL and testbench
==============================

Name: rv_issue_wb

Overview:
Instruction sequencer that drives the ALU-side interface of the basic RISC-V datapath, supporting add, sub, and, or, xor and jal. It owns the PC and a 32x32 register file. It fetches each instruction over a req/ack memory handshake, reads operands, and issues one instruction at a time to the ALU with a single-cycle valid pulse. It then writes the ALU result back to rd and advances the PC from the ALU's next_pc.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ALU_TIMEOUT, 1, cycles after the issue cycle to wait for alu_result_valid before declaring an illegal instruction (range 1..15).

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
run  in  1  enable; start or continue fetching while high
mem_req  out  1  fetch request
mem_addr  out  32  fetch address (= pc)
mem_ack  in  1  fetch data valid this cycle
mem_rdata  in  32  instruction word
alu_valid  out  1  one-cycle issue strobe to ALU
alu_instruction  out  32  instruction to ALU
alu_pc  out  32  PC of issued instruction
alu_rs1_data  out  32  rs1 operand
alu_rs2_data  out  32  rs2 operand
alu_result  in  32  ALU result
alu_next_pc  in  32  ALU next PC
alu_result_valid  in  1  ALU result valid
alu_is_jump  in  1  ALU jump flag (informational; counted)
pc  out  32  architectural PC
instr_count  out  32  retired instruction count
jump_count  out  16  retired jal count
busy  out  1  high in any state except IDLE/TRAP
trap  out  1  sticky error flag
trap_cause  out  2  00 none, 01 illegal/no result, 10 misaligned target
dbg_addr  in  5  register file debug read index
dbg_data  out  32  combinational read of x[dbg_addr]; x0 reads 0

Behaviour:
- Reset (async, resetn low): state=IDLE, pc=RESET_PC, all other outputs 0, all registers x1..x31 = 0. mem_req and alu_valid drop immediately, even mid-fetch or mid-exec.
- States: IDLE, FETCH, ISSUE, EXEC, WB, TRAP.
- IDLE: if run=1, go to FETCH next cycle; else stay.
- FETCH:
  - mem_req=1, mem_addr=pc, both held stable until mem_ack.
  - On the mem_ack cycle, capture mem_rdata into the instruction register and go to ISSUE; mem_req=0 from the next cycle.
  - mem_ack while mem_req=0 is ignored.
- ISSUE:
  - alu_valid=1 for exactly this cycle.
  - alu_instruction/alu_pc/alu_rs1_data/alu_rs2_data are registered and driven from entry to ISSUE, held stable through EXEC and WB.
  - Operand reads use instr[19:15] and instr[24:20]; index 0 yields 0.
- EXEC:
  - Wait counter starts at 1 in the first EXEC cycle.
  - If alu_result_valid=1: capture alu_result, alu_next_pc and alu_is_jump, then go to WB.
  - Else if counter==ALU_TIMEOUT: go to TRAP with trap_cause=01. Else increment the counter.
- WB:
  - If alu_next_pc[1:0]!=0: no register write, pc unchanged, go to TRAP with cause=10.
  - Otherwise:
    - if rd=instr[11:7]!=0, write the result to x[rd];
    - pc<=alu_next_pc;
    - instr_count+=1;
    - jump_count+=1 if is_jump;
    - go to FETCH if run=1, else IDLE.
- run=0 mid-instruction: the current instruction completes through WB, then the block goes to IDLE.
- TRAP: sticky until reset. trap=1, busy=0, mem_req=0, alu_valid=0. pc holds the faulting instruction's PC.
- Writes to x0 are discarded. dbg_data reflects a WB write from the cycle after the write edge.
- Counters wrap: instr_count 0xFFFF_FFFF→0, jump_count 0xFFFF→0.
- Minimum latency is 4 cycles per instruction (FETCH with same-cycle ack, ISSUE, EXEC, WB); each mem_ack wait cycle adds one.

Test Plan:
- Reset with RESET_PC=0x100, run=1, mem_ack immediate; memory holds "add x3,x1,x2" (x1=0, x2=0) → mem_addr=0x100, alu_valid pulses once, x3=0, pc=0x104, instr_count=1, 4 cycles/instr.
- Program sequence using jal to set registers (jal x1,+8 at 0x0 → x1=0x4, pc=0x8), then "sub x5,x1,x1", "xor x6,x1,x0" → dbg x1=4, x5=0, x6=4, jump_count=1.
- "add x0,x1,x1" → dbg_data for x0 stays 0, instr_count increments.
- Unknown word 0xFFFF_FFFF fetched (ALU returns no result_valid) → trap=1, cause=01 one cycle after EXEC, pc unchanged, no further mem_req.
- Stub ALU returns next_pc=0x102 → trap cause=10, no register write; then resetn pulse mid-FETCH with mem_req=1 → mem_req=0 immediately, pc=RESET_PC, trap=0.
- mem_ack delayed 3 cycles with run dropped during EXEC → mem_addr stable for all 4 request cycles, instruction retires, state returns to IDLE, busy=0.

Source files
------------

// File: rtl/rv_issue_wb.sv
`timescale 1ns/1ps
// Single-issue RISC-V sequencer: fetches over req/ack, issues one instruction to an
// external ALU, then writes back the result and advances the PC from the ALU's next_pc.
module rv_issue_wb #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ALU_TIMEOUT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        alu_valid,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_pc,
    output logic [31:0] alu_rs1_data,
    output logic [31:0] alu_rs2_data,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_next_pc,
    input  logic        alu_result_valid,
    input  logic        alu_is_jump,
    output logic [31:0] pc,
    output logic [31:0] instr_count,
    output logic [15:0] jump_count,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_cause,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        WB,
        TRAP
    } state_t;

    localparam logic [3:0] TIMEOUT_CNT = 4'(ALU_TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] xreg [32];
    logic [3:0]  wait_cnt;
    logic [31:0] res_q;
    logic [31:0] npc_q;
    logic        jmp_q;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic        misaligned;

    // Operands are read from the fetched word directly so they are valid on ISSUE entry.
    assign rs1_idx    = mem_rdata[19:15];
    assign rs2_idx    = mem_rdata[24:20];
    assign rd_idx     = alu_instruction[11:7];
    assign misaligned = (npc_q[1:0] != 2'b00);
    assign mem_addr   = pc;
    assign dbg_data   = (dbg_addr == 5'd0) ? '0 : xreg[dbg_addr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        alu_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = ISSUE;
            end
            ISSUE: begin
                alu_valid = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                if (alu_result_valid)            state_nxt = WB;
                else if (wait_cnt == TIMEOUT_CNT) state_nxt = TRAP;
            end
            WB: begin
                if (misaligned) state_nxt = TRAP;
                else if (run)   state_nxt = FETCH;
                else            state_nxt = IDLE;
            end
            TRAP: begin
                busy = 1'b0;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc              <= RESET_PC;
            alu_instruction <= '0;
            alu_pc          <= '0;
            alu_rs1_data    <= '0;
            alu_rs2_data    <= '0;
            wait_cnt        <= '0;
            res_q           <= '0;
            npc_q           <= '0;
            jmp_q           <= 1'b0;
            instr_count     <= '0;
            jump_count      <= '0;
            trap            <= 1'b0;
            trap_cause      <= 2'b00;
            for (int unsigned i = 0; i < 32; i++) begin
                xreg[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        alu_instruction <= mem_rdata;
                        alu_pc          <= pc;
                        alu_rs1_data    <= (rs1_idx == 5'd0) ? '0 : xreg[rs1_idx];
                        alu_rs2_data    <= (rs2_idx == 5'd0) ? '0 : xreg[rs2_idx];
                    end
                end
                ISSUE: begin
                    wait_cnt <= 4'd1;
                end
                EXEC: begin
                    if (alu_result_valid) begin
                        res_q <= alu_result;
                        npc_q <= alu_next_pc;
                        jmp_q <= alu_is_jump;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        trap       <= 1'b1;
                        trap_cause <= 2'b01;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WB: begin
                    if (misaligned) begin
                        trap       <= 1'b1;
                        trap_cause <= 2'b10;
                    end else begin
                        if (rd_idx != 5'd0) xreg[rd_idx] <= res_q;
                        pc          <= npc_q;
                        instr_count <= instr_count + 32'd1;
                        if (jmp_q) jump_count <= jump_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_issue_wb.sv
`timescale 1ns/1ps
// Scoreboard bench for rv_issue_wb: memory and ALU stubs, expected issues queued from a
// reference model of the program, compared on each alu_valid pulse and at end of run.
module tb_rv_issue_wb;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        resetn;
    logic        run;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        alu_valid;
    logic [31:0] alu_instruction;
    logic [31:0] alu_pc;
    logic [31:0] alu_rs1_data;
    logic [31:0] alu_rs2_data;
    logic [31:0] alu_result;
    logic [31:0] alu_next_pc;
    logic        alu_result_valid;
    logic        alu_is_jump;
    logic [31:0] pc;
    logic [31:0] instr_count;
    logic [15:0] jump_count;
    logic        busy;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    rv_issue_wb #(.RESET_PC(RPC), .ALU_TIMEOUT(1)) dut (
        .clk(clk), .resetn(resetn), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_valid(alu_valid), .alu_instruction(alu_instruction), .alu_pc(alu_pc),
        .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data),
        .alu_result(alu_result), .alu_next_pc(alu_next_pc),
        .alu_result_valid(alu_result_valid), .alu_is_jump(alu_is_jump),
        .pc(pc), .instr_count(instr_count), .jump_count(jump_count),
        .busy(busy), .trap(trap), .trap_cause(trap_cause),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
    } issue_t;

    issue_t      sb_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          last_req_len = 0;
    logic [31:0] bad_pc = 32'hFFFF_FFF0;
    logic [31:0] first_addr = '0;
    logic [31:0] m_x [32];
    logic [31:0] exp_pc;
    logic [31:0] exp_icnt;
    logic [31:0] exp_jcnt;
    logic [1:0]  exp_cause;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] jal_op(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic void alu_ref(input logic [31:0] i, input logic [31:0] p,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic ok, output logic [31:0] res,
                                    output logic [31:0] npc, output logic jmp);
        logic [31:0] imm;
        ok  = 1'b1;
        jmp = 1'b0;
        res = '0;
        npc = p + 32'd4;
        imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        if (i[6:0] == 7'h33 && i[31:25] == 7'h00) begin
            case (i[14:12])
                3'd0:    res = a + b;
                3'd4:    res = a ^ b;
                3'd6:    res = a | b;
                3'd7:    res = a & b;
                default: ok = 1'b0;
            endcase
        end else if (i[6:0] == 7'h33 && i[31:25] == 7'h20 && i[14:12] == 3'd0) begin
            res = a - b;
        end else if (i[6:0] == 7'h6f) begin
            res = p + 32'd4;
            npc = p + imm;
            jmp = 1'b1;
        end else begin
            ok = 1'b0;
        end
    endfunction

    // Reference model: walks the program, queues expected issues, records final state.
    task automatic build_expected(input logic [31:0] start, input int max_n);
        logic [31:0] p, ins, a, b, r, n;
        logic        ok, j;
        for (int k = 0; k < 32; k++) m_x[k] = '0;
        p = start;
        exp_icnt = '0;
        exp_jcnt = '0;
        exp_cause = 2'b00;
        for (int k = 0; k < max_n; k++) begin
            ins = mem_rd(p);
            a = m_x[ins[19:15]];
            b = m_x[ins[24:20]];
            sb_q.push_back('{pc: p, instr: ins, a: a, b: b});
            alu_ref(ins, p, a, b, ok, r, n, j);
            if (p == bad_pc) n = 32'h0000_0102;
            if (!ok) begin
                exp_cause = 2'b01;
                break;
            end
            if (n[1:0] != 2'b00) begin
                exp_cause = 2'b10;
                break;
            end
            if (ins[11:7] != 5'd0) m_x[ins[11:7]] = r;
            p = n;
            exp_icnt++;
            if (j) exp_jcnt++;
        end
        exp_pc = p;
    endtask

    // Memory responder: acks after ack_delay extra cycles, address must stay put.
    initial begin
        int wcnt = 0;
        int req_cycles = 0;
        logic [31:0] req_addr = '0;
        bit first_seen = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!resetn) first_seen = 0;
            if (!resetn || !mem_req) begin
                mem_ack = 1'b0;
                wcnt = 0;
                req_cycles = 0;
            end else begin
                if (!first_seen) begin
                    first_addr = mem_addr;
                    first_seen = 1;
                end
                if (req_cycles == 0) req_addr = mem_addr;
                else check("mem_addr_stable", mem_addr, req_addr);
                req_cycles++;
                if (wcnt == ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_rd(mem_addr);
                    last_req_len = req_cycles;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    // ALU stub: answers in the first EXEC cycle; unknown opcodes never answer.
    initial begin
        bit pend = 0;
        logic ok, j;
        logic [31:0] r, n;
        logic [31:0] p_res = '0, p_npc = '0;
        logic p_j = 1'b0;
        alu_result_valid = 1'b0;
        alu_result = '0;
        alu_next_pc = '0;
        alu_is_jump = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pend = 0;
                alu_result_valid = 1'b0;
                alu_is_jump = 1'b0;
            end else begin
                if (pend) begin
                    alu_result_valid = 1'b1;
                    alu_result = p_res;
                    alu_next_pc = p_npc;
                    alu_is_jump = p_j;
                    pend = 0;
                end else begin
                    alu_result_valid = 1'b0;
                    alu_is_jump = 1'b0;
                end
                if (alu_valid) begin
                    alu_ref(alu_instruction, alu_pc, alu_rs1_data, alu_rs2_data, ok, r, n, j);
                    if (alu_pc == bad_pc) n = 32'h0000_0102;
                    pend = ok;
                    p_res = r;
                    p_npc = n;
                    p_j = j;
                end
            end
        end
    end

    // Issue monitor: pops the scoreboard and checks the issue cadence.
    initial begin
        int last_issue = -1;
        issue_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                last_issue = -1;
            end else if (alu_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_issue", alu_pc, 32'hXXXX_XXXX);
                end else begin
                    e = sb_q.pop_front();
                    check("issue_pc", alu_pc, e.pc);
                    check("issue_instr", alu_instruction, e.instr);
                    check("issue_rs1", alu_rs1_data, e.a);
                    check("issue_rs2", alu_rs2_data, e.b);
                end
                if (last_issue >= 0) check("issue_gap", 32'(cyc - last_issue), 32'(4 + ack_delay));
                last_issue = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        run = 1'b0;
        sb_q.delete();
        mem.delete();
        ack_delay = 0;
        bad_pc = 32'hFFFF_FFF0;
        repeat (2) step();
        check("rst_pc", pc, RPC);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_alu_valid", {31'b0, alu_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_trap", {31'b0, trap}, 32'd0);
        check("rst_trap_cause", {30'b0, trap_cause}, 32'd0);
        check("rst_instr_count", instr_count, 32'd0);
        check("rst_jump_count", {16'b0, jump_count}, 32'd0);
        resetn = 1'b1;
        step();
    endtask

    task automatic dbg_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic wait_for_sb(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        check("sb_drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_for_trap(input int budget);
        int k = 0;
        while (!trap && k < budget) begin
            step();
            k++;
        end
        check("trap_timeout", {31'b0, trap}, 32'd1);
    endtask

    task automatic end_checks();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("final_pc", pc, exp_pc);
        check("instr_count", instr_count, exp_icnt);
        check("jump_count", {16'b0, jump_count}, exp_jcnt);
        check("trap", {31'b0, trap}, {31'b0, exp_cause != 2'b00});
        check("trap_cause", {30'b0, trap_cause}, {30'b0, exp_cause});
        check("busy_end", {31'b0, busy}, 32'd0);
        for (int r = 0; r < 32; r++) dbg_check($sformatf("x%0d", r), 5'(r), m_x[r]);
    endtask

    initial begin
        int k;
        resetn = 1'b0;
        run = 1'b0;
        dbg_addr = '0;

        // Program run ending in an unknown word that the ALU never answers.
        do_reset();
        mem[32'h100] = r_op(7'h00, 3'd0, 5'd3, 5'd1, 5'd2);
        mem[32'h104] = jal_op(5'd1, 21'd8);
        mem[32'h10C] = r_op(7'h20, 3'd0, 5'd5, 5'd1, 5'd1);
        mem[32'h110] = r_op(7'h00, 3'd4, 5'd6, 5'd1, 5'd0);
        mem[32'h114] = r_op(7'h00, 3'd0, 5'd0, 5'd1, 5'd1);
        mem[32'h118] = r_op(7'h00, 3'd6, 5'd7, 5'd6, 5'd5);
        mem[32'h11C] = r_op(7'h00, 3'd7, 5'd8, 5'd1, 5'd6);
        mem[32'h120] = 32'hFFFF_FFFF;
        build_expected(RPC, 20);
        run = 1'b1;
        k = 0;
        while (instr_count != 32'd1 && k < 20) begin
            step();
            k++;
        end
        check("first_fetch_addr", first_addr, 32'h100);
        check("pc_after_add", pc, 32'h104);
        check("icnt_after_add", instr_count, 32'd1);
        wait_for_sb(100);
        check("trap_in_exec", {31'b0, trap}, 32'd0);
        step();
        check("trap_after_exec", {31'b0, trap}, 32'd1);
        check("cause_after_exec", {30'b0, trap_cause}, 32'd1);
        repeat (5) begin
            step();
            check("no_req_in_trap", {31'b0, mem_req}, 32'd0);
        end
        end_checks();
        dbg_check("x1_jal_link", 5'd1, 32'h108);
        dbg_check("x6_xor", 5'd6, 32'h108);
        dbg_check("x0_zero", 5'd0, 32'h0);
        check("icnt_const", instr_count, 32'd7);
        check("jcnt_const", {16'b0, jump_count}, 32'd1);

        // Misaligned next_pc from the ALU: trap cause 10, no writeback.
        do_reset();
        mem[32'h100] = jal_op(5'd2, 21'd4);
        mem[32'h104] = r_op(7'h00, 3'd0, 5'd4, 5'd2, 5'd2);
        bad_pc = 32'h104;
        build_expected(RPC, 10);
        run = 1'b1;
        wait_for_trap(60);
        step();
        end_checks();
        dbg_check("x4_unwritten", 5'd4, 32'h0);
        check("misalign_pc", pc, 32'h104);

        // Async reset in the middle of a long fetch.
        do_reset();
        mem[32'h100] = jal_op(5'd3, 21'd4);
        build_expected(RPC, 1);
        run = 1'b1;
        k = 0;
        while (instr_count != 32'd1 && k < 20) begin
            step();
            k++;
        end
        ack_delay = 10;
        repeat (2) step();
        check("midfetch_req", {31'b0, mem_req}, 32'd1);
        check("midfetch_addr", mem_addr, 32'h104);
        dbg_addr = 5'd3;
        #2;
        check("midfetch_x3", dbg_data, 32'h104);
        resetn = 1'b0;
        #1;
        check("async_rst_req", {31'b0, mem_req}, 32'd0);
        check("async_rst_pc", pc, RPC);
        check("async_rst_trap", {31'b0, trap}, 32'd0);
        check("async_rst_icnt", instr_count, 32'd0);
        check("async_rst_x3", dbg_data, 32'h0);

        // Slow ack plus run dropped during EXEC: retire, then park in IDLE.
        do_reset();
        mem[32'h100] = jal_op(5'd9, 21'd12);
        ack_delay = 3;
        build_expected(RPC, 1);
        run = 1'b1;
        wait_for_sb(40);
        run = 1'b0;
        k = 0;
        while (busy && k < 20) begin
            step();
            k++;
        end
        check("req_len", 32'(last_req_len), 32'd4);
        repeat (3) begin
            step();
            check("idle_no_req", {31'b0, mem_req}, 32'd0);
            check("idle_not_busy", {31'b0, busy}, 32'd0);
        end
        end_checks();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
